step_conditioner: RTL and testbench

//   Conditions the raw board step button into clean single-cycle step pulses
//   for the program counter's btn input. Synchronizes, debounces, detects the

---
 rtl/step_conditioner.sv | 185 ++++++++++++++++++
 tb/tb_step_conditioner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_conditioner.sv
`default_nettype none
//==============================================================================
// Module      : step_conditioner
// Description : Turns the raw, bouncy board step button into clean one-cycle
//               step pulses for the program counter. The button passes through
//               a two-flop synchronizer and is then debounced. The press is
//               detected, and the block can optionally auto-repeat while the
//               button is held.
//
// Ports       :
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous, active-high reset
//   btn_raw      in   1  asynchronous, bouncy button level
//   repeat_en    in   1  1 = auto-repeat while held, 0 = one step per press
//   step         out  1  one-cycle step pulse
//   pressed      out  1  debounced button level
//   step_count   out  8  steps issued since reset (modulo 256)
//
// Revision    : 1.0  initial release
//==============================================================================
module step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter int CNT_W           = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       repeat_en,
    output logic       step,
    output logic       pressed,
    output logic [7:0] step_count
);

    // State encoding
    localparam logic [2:0] c_IDLE         = 3'd0;
    localparam logic [2:0] c_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] c_HELD         = 3'd2;
    localparam logic [2:0] c_REPEAT       = 3'd3;
    localparam logic [2:0] c_RELEASE_WAIT = 3'd4;

    // Terminal count values for each timed phase
    localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step;
    logic             r_pressed;
    logic [7:0]       r_step_count;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_step_nxt;
    logic             w_pressed_nxt;

    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    //--------------------------------------------------------------------------
    // Registers: synchronizer, FSM state, phase counter and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_state      <= c_IDLE;
            r_cnt        <= c_CNT_ZERO;
            r_step       <= 1'b0;
            r_pressed    <= 1'b0;
            r_step_count <= 8'd0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_step    <= w_step_nxt;
            r_pressed <= w_pressed_nxt;
            // The count moves on the same edge that raises step
            if (w_step_nxt) begin
                r_step_count <= r_step_count + 8'd1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic. Each state checks, in order: the button level
    // (release or bounce), then repeat_en, and finally the phase counter.
    // The counter restarts from zero on every state entry.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_step_nxt    = 1'b0;
        w_pressed_nxt = r_pressed;

        case (r_state)
            c_IDLE: begin
                w_pressed_nxt = 1'b0;
                w_cnt_nxt     = c_CNT_ZERO;
                if (r_sync2) begin
                    w_state_nxt = c_PRESS_WAIT;
                end
            end

            c_PRESS_WAIT: begin
                if (!r_sync2) begin
                    // The level dropped before it was stable long enough, so treat it as bounce
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt   = c_HELD;
                    w_cnt_nxt     = c_CNT_ZERO;
                    w_step_nxt    = 1'b1;
                    w_pressed_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            c_HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = c_RELEASE_WAIT;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (repeat_en && (r_cnt == c_HOLD_LAST)) begin
                    w_state_nxt = c_REPEAT;
                    w_cnt_nxt   = c_CNT_ZERO;
                    w_step_nxt  = 1'b1;
                end else if (r_cnt != c_HOLD_LAST) begin
                    // With repeat disabled the counter parks at its last value.
                    // Enabling repeat later then fires on the next cycle.
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            c_REPEAT: begin
                if (!r_sync2) begin
                    w_state_nxt = c_RELEASE_WAIT;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (!repeat_en) begin
                    // Drop back to HELD so a full hold delay must pass before the next repeat
                    w_state_nxt = c_HELD;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_REP_LAST) begin
                    w_cnt_nxt  = c_CNT_ZERO;
                    w_step_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            c_RELEASE_WAIT: begin
                if (r_sync2) begin
                    // This is release bounce: the press is still valid, so no new step is issued
                    w_state_nxt = c_HELD;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt   = c_IDLE;
                    w_cnt_nxt     = c_CNT_ZERO;
                    w_pressed_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            default: begin
                w_state_nxt   = c_IDLE;
                w_cnt_nxt     = c_CNT_ZERO;
                w_pressed_nxt = 1'b0;
            end
        endcase
    end

    assign step       = r_step;
    assign pressed    = r_pressed;
    assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_step_conditioner.sv
`default_nettype none
//==============================================================================
// Module      : tb_step_conditioner
// Description : Scoreboard bench for step_conditioner. Stimulus pushes the
//               edge number and step_count of every expected step pulse. A
//               monitor pops one entry for each step it observes and compares.
//               Each test sets btn_raw before edge base+k, so "edge k" below
//               is the k-th edge of the current test.
// Revision    : 1.0  initial release
//==============================================================================
module tb_step_conditioner;

    localparam int c_DEB   = 4;
    localparam int c_HOLD  = 10;
    localparam int c_REP   = 3;
    localparam int c_CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b1;
    logic       repeat_en = 1'b0;
    logic       step;
    logic       pressed;
    logic [7:0] step_count;

    step_conditioner #(
        .DEBOUNCE_CYCLES (c_DEB),
        .HOLD_CYCLES     (c_HOLD),
        .REPEAT_CYCLES   (c_REP),
        .CNT_W           (c_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .repeat_en  (repeat_en),
        .step       (step),
        .pressed    (pressed),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    int unsigned edge_no = 0;
    int unsigned base    = 0;
    int          checks  = 0;
    int          errors  = 0;
    logic [7:0]  exp_count = 8'd0;

    int unsigned exp_edge_q[$];
    logic [7:0]  exp_cnt_q[$];

    // Monitor: this process numbers the edges and checks every observed step pulse
    initial begin
        int unsigned e;
        logic [7:0]  c;
        forever begin
            @(posedge clk);
            edge_no++;
            #1;
            if (step === 1'b1) begin
                checks++;
                if (exp_edge_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step: step at edge %0d (count %0d), required no step",
                             edge_no - base, step_count);
                end else begin
                    e = exp_edge_q.pop_front();
                    c = exp_cnt_q.pop_front();
                    if (edge_no != e || step_count !== c) begin
                        errors++;
                        $display("FAIL step_timing: got edge %0d count %0d, required edge %0d count %0d",
                                 edge_no - base, step_count, e - base, c);
                    end
                end
            end
        end
    end

    // Expect a step after edge base+k that carries the next step_count value
    task automatic push_step(input int unsigned k);
        exp_count = exp_count + 8'd1;
        exp_edge_q.push_back(base + k);
        exp_cnt_q.push_back(exp_count);
    endtask

    task automatic goto(input int unsigned k);
        while (edge_no < base + k) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_drained(input string name);
        checks++;
        if (exp_edge_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected step(s) never seen, required 0", name, exp_edge_q.size());
        end
        exp_edge_q.delete();
        exp_cnt_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn_raw = 1'b0;
        repeat_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_count = 8'd0;
        base = edge_no;
    endtask

    task automatic start_test();
        @(negedge clk);
        base = edge_no;
    endtask

    initial begin
        logic seq [8];
        seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state, with the button held high throughout reset
        repeat (3) @(negedge clk);
        chk("reset_step", {7'd0, step}, 8'd0);
        chk("reset_pressed", {7'd0, pressed}, 8'd0);
        chk("reset_count", step_count, 8'd0);

        // Clean press, no repeat: one step after edge 7, then release debounced
        do_reset();
        start_test();
        btn_raw = 1'b1;
        push_step(7);
        goto(6);  chk("clean_pressed_e6", {7'd0, pressed}, 8'd0);
        goto(7);  chk("clean_pressed_e7", {7'd0, pressed}, 8'd1);
                  chk("clean_count_e7", step_count, 8'd1);
        goto(30); btn_raw = 1'b0;             // first sampled low at edge 31
        goto(36); chk("clean_rel_e36", {7'd0, pressed}, 8'd1);
        goto(37); chk("clean_rel_e37", {7'd0, pressed}, 8'd0);
        chk("clean_count_end", step_count, 8'd1);
        chk_drained("clean_drained");

        // Bounce on the press: no step is ever issued
        do_reset();
        start_test();
        for (int i = 0; i < 8; i++) begin
            goto(i);
            btn_raw = seq[i];
        end
        goto(8);  btn_raw = 1'b0;
        goto(6);
        goto(20); chk("bounce_pressed", {7'd0, pressed}, 8'd0);
                  chk("bounce_count", step_count, 8'd0);
        chk_drained("bounce_drained");

        // Auto-repeat: steps at 7, 17, 20, 23, 26; release resolves before 29
        do_reset();
        start_test();
        repeat_en = 1'b1;
        btn_raw = 1'b1;
        push_step(7); push_step(17); push_step(20); push_step(23); push_step(26);
        goto(18); chk("repeat_pressed", {7'd0, pressed}, 8'd1);
        goto(26); btn_raw = 1'b0;             // first sampled low at edge 27
        goto(40); chk("repeat_count", step_count, 8'd5);
                  chk("repeat_pressed_end", {7'd0, pressed}, 8'd0);
        chk_drained("repeat_drained");

        // Release bounce: samples 0,1,0,0,... at edges 13.. give no second step
        do_reset();
        start_test();
        btn_raw = 1'b1;
        push_step(7);
        goto(12); btn_raw = 1'b0;
        goto(13); btn_raw = 1'b1;
        goto(14); btn_raw = 1'b0;
        goto(20); chk("relb_pressed_e20", {7'd0, pressed}, 8'd1);
        goto(21); chk("relb_pressed_e21", {7'd0, pressed}, 8'd0);
        goto(30); chk("relb_count", step_count, 8'd1);
        chk_drained("relb_drained");

        // Reset while in PRESS_WAIT (sampled at edge 4). The button is still held, so it is re-debounced and steps at 11
        do_reset();
        start_test();
        btn_raw = 1'b1;
        goto(3);  rst = 1'b1;
        goto(4);  rst = 1'b0;
        exp_count = 8'd0;
        push_step(11);
        goto(10); chk("rstmid_pressed_e10", {7'd0, pressed}, 8'd0);
        goto(11); chk("rstmid_pressed_e11", {7'd0, pressed}, 8'd1);
        goto(14); chk("rstmid_count", step_count, 8'd1);
        btn_raw = 1'b0;
        goto(30);
        chk_drained("rstmid_drained");

        // Dropping repeat_en in REPEAT returns to HELD, so the next step needs a full HOLD again
        do_reset();
        start_test();
        repeat_en = 1'b1;
        btn_raw = 1'b1;
        push_step(7); push_step(17); push_step(20);
        goto(20); repeat_en = 1'b0;           // seen at edge 21
        goto(24); repeat_en = 1'b1;           // seen from edge 25
        push_step(31); push_step(34); push_step(37);
        goto(28); chk("drop_pressed", {7'd0, pressed}, 8'd1);
                  chk("drop_count_e28", step_count, 8'd3);
        goto(35); btn_raw = 1'b0;             // first sampled low at edge 36
        goto(45); chk("drop_count_end", step_count, 8'd6);
        chk_drained("drop_drained");

        // 256 clean presses: step_count wraps back to 0
        do_reset();
        for (int p = 0; p < 256; p++) begin
            start_test();
            btn_raw = 1'b1;
            push_step(7);
            goto(8);  btn_raw = 1'b0;
            goto(16);
        end
        chk("wrap_count", step_count, 8'd0);
        chk("wrap_pressed", {7'd0, pressed}, 8'd0);
        chk_drained("wrap_drained");

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
